ex_operand_stage: RTL and testbench

ID/EX pipeline register and operand-forwarding stage of the pipelined RV32I core, sitting directly upstream of the ALU. It captures one decoded instruction per cycle from ID and resolves RAW hazards against the MEM and WB stages. It drives the ALU's two 32-bit operands and its 4-bit opcode. It supports stall (hold) and flush (bubble insertion) from the hazard unit.

---
 rtl/ex_operand_stage.sv | 201 ++++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   ID/EX pipeline register plus operand forwarding for the RV32I core. It captures one decoded
//   instruction per cycle from ID. It resolves RAW hazards against the MEM and WB stages, then
//   drives the ALU operands and opcode. The hazard unit can stall (hold) or flush (bubble) it.
//
// Configuration:
//   EX_FORWARD_EN  defined   : MEM/WB forwarding enabled. rs data is refreshed from the
//                              forwarded values while stalled.
//                  undefined : operands come from the registered rs data only. mem_*/wb_* are
//                              unused, and the hazard unit must stall until the register file
//                              has been written.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   id_*                  decoded instruction fields from ID
//   stall_i, flush_i      hazard-unit controls (flush wins over stall)
//   mem_*, wb_*           producer qualifiers, destination and result for forwarding
//   ex_valid_o            EX slot valid
//   operand1_o/2_o        ALU operands
//   alu_op_o              ALU opcode (0 for a bubble)
//   ex_rs2_data_o         forwarded rs2, used as store data
//   ex_pc_o, ex_rd_*_o    registered PC and destination; rd write enable qualified by valid

module ex_operand_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              id_valid_i,
   input  logic [DATA_W-1:0] id_pc_i,
   input  logic [REG_AW-1:0] id_rs1_addr_i,
   input  logic [REG_AW-1:0] id_rs2_addr_i,
   input  logic [DATA_W-1:0] id_rs1_data_i,
   input  logic [DATA_W-1:0] id_rs2_data_i,
   input  logic [DATA_W-1:0] id_imm_i,
   input  logic [3:0]        id_alu_op_i,
   input  logic              id_op1_sel_i,
   input  logic              id_op2_sel_i,
   input  logic [REG_AW-1:0] id_rd_addr_i,
   input  logic              id_rd_wren_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              mem_valid_i,
   input  logic              mem_rd_wren_i,
   input  logic [REG_AW-1:0] mem_rd_addr_i,
   input  logic [DATA_W-1:0] mem_fwd_data_i,
   input  logic              wb_valid_i,
   input  logic              wb_rd_wren_i,
   input  logic [REG_AW-1:0] wb_rd_addr_i,
   input  logic [DATA_W-1:0] wb_fwd_data_i,
   output logic              ex_valid_o,
   output logic [DATA_W-1:0] operand1_o,
   output logic [DATA_W-1:0] operand2_o,
   output logic [3:0]        alu_op_o,
   output logic [DATA_W-1:0] ex_rs2_data_o,
   output logic [DATA_W-1:0] ex_pc_o,
   output logic [REG_AW-1:0] ex_rd_addr_o,
   output logic              ex_rd_wren_o
);

   logic              valid_q,    valid_d;
   logic [DATA_W-1:0] pc_q,       pc_d;
   logic [REG_AW-1:0] rs1_addr_q, rs1_addr_d;
   logic [REG_AW-1:0] rs2_addr_q, rs2_addr_d;
   logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
   logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
   logic [DATA_W-1:0] imm_q,      imm_d;
   logic [3:0]        alu_op_q,   alu_op_d;
   logic              op1_sel_q,  op1_sel_d;
   logic              op2_sel_q,  op2_sel_d;
   logic [REG_AW-1:0] rd_addr_q,  rd_addr_d;
   logic              rd_wren_q,  rd_wren_d;

   logic [DATA_W-1:0] fwd1, fwd2;

`ifdef EX_FORWARD_EN
   logic mem_hit1, mem_hit2, wb_hit1, wb_hit2;

   // x0 is hardwired to zero, so a write to it must never be forwarded.
   assign mem_hit1 = mem_valid_i & mem_rd_wren_i & (mem_rd_addr_i == rs1_addr_q)
                     & (rs1_addr_q != '0);
   assign mem_hit2 = mem_valid_i & mem_rd_wren_i & (mem_rd_addr_i == rs2_addr_q)
                     & (rs2_addr_q != '0);
   assign wb_hit1  = wb_valid_i & wb_rd_wren_i & (wb_rd_addr_i == rs1_addr_q)
                     & (rs1_addr_q != '0);
   assign wb_hit2  = wb_valid_i & wb_rd_wren_i & (wb_rd_addr_i == rs2_addr_q)
                     & (rs2_addr_q != '0);

   // MEM holds the younger result, so it takes priority over WB.
   always_comb begin
      fwd1 = rs1_data_q;
      if (mem_hit1)     fwd1 = mem_fwd_data_i;
      else if (wb_hit1) fwd1 = wb_fwd_data_i;
   end

   always_comb begin
      fwd2 = rs2_data_q;
      if (mem_hit2)     fwd2 = mem_fwd_data_i;
      else if (wb_hit2) fwd2 = wb_fwd_data_i;
   end
`else
   assign fwd1 = rs1_data_q;
   assign fwd2 = rs2_data_q;

   logic unused_fwd_inputs;
   assign unused_fwd_inputs = ^{mem_valid_i, mem_rd_wren_i, mem_rd_addr_i, mem_fwd_data_i,
                                wb_valid_i, wb_rd_wren_i, wb_rd_addr_i, wb_fwd_data_i,
                                rs1_addr_q, rs2_addr_q};
`endif

   always_comb begin
      // Default: load from ID.
      valid_d    = id_valid_i;
      pc_d       = id_pc_i;
      rs1_addr_d = id_rs1_addr_i;
      rs2_addr_d = id_rs2_addr_i;
      rs1_data_d = id_rs1_data_i;
      rs2_data_d = id_rs2_data_i;
      imm_d      = id_imm_i;
      alu_op_d   = id_alu_op_i;
      op1_sel_d  = id_op1_sel_i;
      op2_sel_d  = id_op2_sel_i;
      rd_addr_d  = id_rd_addr_i;
      rd_wren_d  = id_rd_wren_i & id_valid_i;

      if (flush_i) begin
         valid_d    = 1'b0;
         pc_d       = '0;
         rs1_addr_d = '0;
         rs2_addr_d = '0;
         rs1_data_d = '0;
         rs2_data_d = '0;
         imm_d      = '0;
         alu_op_d   = 4'b0000;
         op1_sel_d  = 1'b0;
         op2_sel_d  = 1'b0;
         rd_addr_d  = '0;
         rd_wren_d  = 1'b0;
      end else if (stall_i) begin
         valid_d    = valid_q;
         pc_d       = pc_q;
         rs1_addr_d = rs1_addr_q;
         rs2_addr_d = rs2_addr_q;
         imm_d      = imm_q;
         alu_op_d   = alu_op_q;
         op1_sel_d  = op1_sel_q;
         op2_sel_d  = op2_sel_q;
         rd_addr_d  = rd_addr_q;
         rd_wren_d  = rd_wren_q;
`ifdef EX_FORWARD_EN
         // Capture forwarded values so they survive the producer retiring during the stall.
         rs1_data_d = fwd1;
         rs2_data_d = fwd2;
`else
         rs1_data_d = rs1_data_q;
         rs2_data_d = rs2_data_q;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         alu_op_q   <= 4'b0000;
         op1_sel_q  <= 1'b0;
         op2_sel_q  <= 1'b0;
         rd_addr_q  <= '0;
         rd_wren_q  <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         alu_op_q   <= alu_op_d;
         op1_sel_q  <= op1_sel_d;
         op2_sel_q  <= op2_sel_d;
         rd_addr_q  <= rd_addr_d;
         rd_wren_q  <= rd_wren_d;
      end
   end

   assign ex_valid_o    = valid_q;
   assign operand1_o    = op1_sel_q ? pc_q : fwd1;
   assign operand2_o    = op2_sel_q ? imm_q : fwd2;
   assign alu_op_o      = alu_op_q;
   assign ex_rs2_data_o = fwd2;
   assign ex_pc_o       = pc_q;
   assign ex_rd_addr_o  = rd_addr_q;
   assign ex_rd_wren_o  = rd_wren_q & valid_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed testbench for ex_operand_stage. Expected values for forwarding cases depend on
// whether EX_FORWARD_EN is defined for the build.

module tb_ex_operand_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        id_valid_i;
   logic [31:0] id_pc_i;
   logic [4:0]  id_rs1_addr_i, id_rs2_addr_i;
   logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
   logic [3:0]  id_alu_op_i;
   logic        id_op1_sel_i, id_op2_sel_i;
   logic [4:0]  id_rd_addr_i;
   logic        id_rd_wren_i;
   logic        stall_i, flush_i;
   logic        mem_valid_i, mem_rd_wren_i;
   logic [4:0]  mem_rd_addr_i;
   logic [31:0] mem_fwd_data_i;
   logic        wb_valid_i, wb_rd_wren_i;
   logic [4:0]  wb_rd_addr_i;
   logic [31:0] wb_fwd_data_i;
   logic        ex_valid_o;
   logic [31:0] operand1_o, operand2_o;
   logic [3:0]  alu_op_o;
   logic [31:0] ex_rs2_data_o, ex_pc_o;
   logic [4:0]  ex_rd_addr_o;
   logic        ex_rd_wren_o;

   int unsigned total_cnt = 0;
   int unsigned pass_cnt  = 0;

`ifdef EX_FORWARD_EN
   localparam bit Fwd = 1'b1;
`else
   localparam bit Fwd = 1'b0;
`endif

   ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .id_valid_i     (id_valid_i),
      .id_pc_i        (id_pc_i),
      .id_rs1_addr_i  (id_rs1_addr_i),
      .id_rs2_addr_i  (id_rs2_addr_i),
      .id_rs1_data_i  (id_rs1_data_i),
      .id_rs2_data_i  (id_rs2_data_i),
      .id_imm_i       (id_imm_i),
      .id_alu_op_i    (id_alu_op_i),
      .id_op1_sel_i   (id_op1_sel_i),
      .id_op2_sel_i   (id_op2_sel_i),
      .id_rd_addr_i   (id_rd_addr_i),
      .id_rd_wren_i   (id_rd_wren_i),
      .stall_i        (stall_i),
      .flush_i        (flush_i),
      .mem_valid_i    (mem_valid_i),
      .mem_rd_wren_i  (mem_rd_wren_i),
      .mem_rd_addr_i  (mem_rd_addr_i),
      .mem_fwd_data_i (mem_fwd_data_i),
      .wb_valid_i     (wb_valid_i),
      .wb_rd_wren_i   (wb_rd_wren_i),
      .wb_rd_addr_i   (wb_rd_addr_i),
      .wb_fwd_data_i  (wb_fwd_data_i),
      .ex_valid_o     (ex_valid_o),
      .operand1_o     (operand1_o),
      .operand2_o     (operand2_o),
      .alu_op_o       (alu_op_o),
      .ex_rs2_data_o  (ex_rs2_data_o),
      .ex_pc_o        (ex_pc_o),
      .ex_rd_addr_o   (ex_rd_addr_o),
      .ex_rd_wren_o   (ex_rd_wren_o)
   );

   always #5 clk_i = ~clk_i;

   // Advance one rising edge and settle before sampling/driving.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
      id_valid_i = 1'b0; id_pc_i = '0; id_rs1_addr_i = '0; id_rs2_addr_i = '0;
      id_rs1_data_i = '0; id_rs2_data_i = '0; id_imm_i = '0; id_alu_op_i = '0;
      id_op1_sel_i = 1'b0; id_op2_sel_i = 1'b0; id_rd_addr_i = '0; id_rd_wren_i = 1'b0;
      mem_valid_i = 1'b0; mem_rd_wren_i = 1'b0; mem_rd_addr_i = '0; mem_fwd_data_i = '0;
      wb_valid_i = 1'b0; wb_rd_wren_i = 1'b0; wb_rd_addr_i = '0; wb_fwd_data_i = '0;
   endtask

   task automatic load_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                             input logic [4:0] rs2, input logic [31:0] d2,
                             input logic [31:0] imm, input logic [3:0] op,
                             input logic s1, input logic s2, input logic [4:0] rd,
                             input logic wren);
      id_valid_i = 1'b1; id_pc_i = pc; id_rs1_addr_i = rs1; id_rs1_data_i = d1;
      id_rs2_addr_i = rs2; id_rs2_data_i = d2; id_imm_i = imm; id_alu_op_i = op;
      id_op1_sel_i = s1; id_op2_sel_i = s2; id_rd_addr_i = rd; id_rd_wren_i = wren;
   endtask

   task automatic test_reset();
      clear_inputs();
      load_instr(32'h0000_0100, 5'd1, 32'hAAAA_0001, 5'd2, 32'hBBBB_0002, 32'h0000_0040,
                 4'd5, 1'b0, 1'b0, 5'd4, 1'b1);
      rst_i = 1'b1;
      tick();
      tick();
      total_cnt++;
      if (ex_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", ex_valid_o);
      else pass_cnt++;
      total_cnt++;
      if (operand1_o !== 32'h0) $display("FAIL reset_op1: got %h want 0", operand1_o);
      else pass_cnt++;
      total_cnt++;
      if (operand2_o !== 32'h0) $display("FAIL reset_op2: got %h want 0", operand2_o);
      else pass_cnt++;
      total_cnt++;
      if (alu_op_o !== 4'h0) $display("FAIL reset_aluop: got %h want 0", alu_op_o);
      else pass_cnt++;
      total_cnt++;
      if (ex_rs2_data_o !== 32'h0) $display("FAIL reset_rs2: got %h want 0", ex_rs2_data_o);
      else pass_cnt++;
      total_cnt++;
      if (ex_pc_o !== 32'h0) $display("FAIL reset_pc: got %h want 0", ex_pc_o);
      else pass_cnt++;
      total_cnt++;
      if (ex_rd_addr_o !== 5'h0) $display("FAIL reset_rd: got %h want 0", ex_rd_addr_o);
      else pass_cnt++;
      total_cnt++;
      if (ex_rd_wren_o !== 1'b0) $display("FAIL reset_wren: got %b want 0", ex_rd_wren_o);
      else pass_cnt++;
      // First instruction after release appears one edge later.
      rst_i = 1'b0;
      tick();
      total_cnt++;
      if (ex_valid_o !== 1'b1) $display("FAIL post_reset_valid: got %b want 1", ex_valid_o);
      else pass_cnt++;
      total_cnt++;
      if (ex_pc_o !== 32'h0000_0100) $display("FAIL post_reset_pc: got %h want 100", ex_pc_o);
      else pass_cnt++;
      total_cnt++;
      if (alu_op_o !== 4'd5) $display("FAIL post_reset_aluop: got %h want 5", alu_op_o);
      else pass_cnt++;
      total_cnt++;
      if (operand1_o !== 32'hAAAA_0001)
         $display("FAIL post_reset_op1: got %h want aaaa0001", operand1_o);
      else pass_cnt++;
      total_cnt++;
      if (ex_rd_addr_o !== 5'd4 || ex_rd_wren_o !== 1'b1)
         $display("FAIL post_reset_rd: got %h/%b want 04/1", ex_rd_addr_o, ex_rd_wren_o);
      else pass_cnt++;
   endtask

   task automatic test_operand_select();
      clear_inputs();
      load_instr(32'h0000_2000, 5'd8, 32'h1111_1111, 5'd9, 32'h2222_2222, 32'hFFFF_F800,
                 4'd3, 1'b1, 1'b1, 5'd10, 1'b1);
      tick();
      total_cnt++;
      if (operand1_o !== 32'h0000_2000) $display("FAIL sel_pc: got %h want 2000", operand1_o);
      else pass_cnt++;
      total_cnt++;
      if (operand2_o !== 32'hFFFF_F800)
         $display("FAIL sel_imm: got %h want fffff800", operand2_o);
      else pass_cnt++;
      total_cnt++;
      if (ex_rs2_data_o !== 32'h2222_2222)
         $display("FAIL sel_store: got %h want 22222222", ex_rs2_data_o);
      else pass_cnt++;
      // Invalid ID slot: rd_wren must be masked even though id_rd_wren_i is 1.
      id_valid_i = 1'b0;
      tick();
      total_cnt++;
      if (ex_valid_o !== 1'b0 || ex_rd_wren_o !== 1'b0)
         $display("FAIL invalid_slot: got %b/%b want 0/0", ex_valid_o, ex_rd_wren_o);
      else pass_cnt++;
   endtask

   task automatic test_mem_forward();
      clear_inputs();
      load_instr(32'h0000_0300, 5'd5, 32'h0000_0011, 5'd6, 32'h0000_0022, 32'h0,
                 4'd1, 1'b0, 1'b0, 5'd12, 1'b1);
      tick();
      id_valid_i = 1'b0;
      mem_valid_i = 1'b1; mem_rd_wren_i = 1'b1; mem_rd_addr_i = 5'd5;
      mem_fwd_data_i = 32'hDEAD_BEEF;
      #1;
      total_cnt++;
      if (operand1_o !== (Fwd ? 32'hDEAD_BEEF : 32'h0000_0011))
         $display("FAIL mem_fwd: got %h want %h", operand1_o,
                  Fwd ? 32'hDEAD_BEEF : 32'h0000_0011);
      else pass_cnt++;
      // Address match but producer not writing: no forward.
      mem_rd_wren_i = 1'b0;
      #1;
      total_cnt++;
      if (operand1_o !== 32'h0000_0011)
         $display("FAIL mem_nowren: got %h want 00000011", operand1_o);
      else pass_cnt++;
      mem_rd_wren_i = 1'b1; mem_valid_i = 1'b0;
      #1;
      total_cnt++;
      if (operand1_o !== 32'h0000_0011)
         $display("FAIL mem_invalid: got %h want 00000011", operand1_o);
      else pass_cnt++;
   endtask

   task automatic test_mem_over_wb();
      clear_inputs();
      load_instr(32'h0000_0400, 5'd1, 32'h0, 5'd7, 32'h0000_0055, 32'h0,
                 4'd2, 1'b0, 1'b0, 5'd13, 1'b1);
      tick();
      mem_valid_i = 1'b1; mem_rd_wren_i = 1'b1; mem_rd_addr_i = 5'd7; mem_fwd_data_i = 32'h2;
      wb_valid_i = 1'b1; wb_rd_wren_i = 1'b1; wb_rd_addr_i = 5'd7; wb_fwd_data_i = 32'h1;
      #1;
      total_cnt++;
      if (operand2_o !== (Fwd ? 32'h2 : 32'h55))
         $display("FAIL mem_over_wb_op2: got %h want %h", operand2_o, Fwd ? 32'h2 : 32'h55);
      else pass_cnt++;
      total_cnt++;
      if (ex_rs2_data_o !== (Fwd ? 32'h2 : 32'h55))
         $display("FAIL mem_over_wb_store: got %h want %h", ex_rs2_data_o,
                  Fwd ? 32'h2 : 32'h55);
      else pass_cnt++;
      mem_valid_i = 1'b0;
      #1;
      total_cnt++;
      if (operand2_o !== (Fwd ? 32'h1 : 32'h55))
         $display("FAIL wb_fwd_op2: got %h want %h", operand2_o, Fwd ? 32'h1 : 32'h55);
      else pass_cnt++;
   endtask

   task automatic test_x0_guard();
      clear_inputs();
      load_instr(32'h0000_0500, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0,
                 4'd0, 1'b0, 1'b0, 5'd1, 1'b1);
      tick();
      mem_valid_i = 1'b1; mem_rd_wren_i = 1'b1; mem_rd_addr_i = 5'd0;
      mem_fwd_data_i = 32'hFFFF_FFFF;
      #1;
      total_cnt++;
      if (operand1_o !== 32'h0) $display("FAIL x0_mem_op1: got %h want 0", operand1_o);
      else pass_cnt++;
      mem_valid_i = 1'b0;
      wb_valid_i = 1'b1; wb_rd_wren_i = 1'b1; wb_rd_addr_i = 5'd0; wb_fwd_data_i = 32'hFFFF_FFFF;
      #1;
      total_cnt++;
      if (operand2_o !== 32'h0) $display("FAIL x0_wb_op2: got %h want 0", operand2_o);
      else pass_cnt++;
   endtask

   task automatic test_stall_refresh();
      clear_inputs();
      load_instr(32'h0000_0600, 5'd3, 32'h0000_0099, 5'd4, 32'h0000_0044, 32'h0,
                 4'd6, 1'b0, 1'b0, 5'd14, 1'b1);
      tick();
      // New ID contents must not leak into EX while stalled.
      load_instr(32'h0000_0700, 5'd9, 32'hCCCC_CCCC, 5'd9, 32'hCCCC_CCCC, 32'h0,
                 4'd9, 1'b0, 1'b0, 5'd15, 1'b1);
      stall_i = 1'b1;
      wb_valid_i = 1'b1; wb_rd_wren_i = 1'b1; wb_rd_addr_i = 5'd3; wb_fwd_data_i = 32'h1234;
      #1;
      total_cnt++;
      if (operand1_o !== (Fwd ? 32'h1234 : 32'h99))
         $display("FAIL stall_wb_fwd: got %h want %h", operand1_o, Fwd ? 32'h1234 : 32'h99);
      else pass_cnt++;
      tick();
      wb_valid_i = 1'b0;
      #1;
      total_cnt++;
      if (operand1_o !== (Fwd ? 32'h1234 : 32'h99))
         $display("FAIL stall_refresh: got %h want %h", operand1_o, Fwd ? 32'h1234 : 32'h99);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (operand1_o !== (Fwd ? 32'h1234 : 32'h99))
         $display("FAIL stall_hold2: got %h want %h", operand1_o, Fwd ? 32'h1234 : 32'h99);
      else pass_cnt++;
      total_cnt++;
      if (ex_pc_o !== 32'h0000_0600 || alu_op_o !== 4'd6 || ex_rd_addr_o !== 5'd14)
         $display("FAIL stall_hold_fields: got %h/%h/%h want 00000600/6/0e",
                  ex_pc_o, alu_op_o, ex_rd_addr_o);
      else pass_cnt++;
      total_cnt++;
      if (ex_rs2_data_o !== 32'h44)
         $display("FAIL stall_rs2_hold: got %h want 00000044", ex_rs2_data_o);
      else pass_cnt++;
      stall_i = 1'b0;
      tick();
      total_cnt++;
      if (ex_pc_o !== 32'h0000_0700 || operand1_o !== 32'hCCCC_CCCC)
         $display("FAIL stall_release: got %h/%h want 00000700/cccccccc", ex_pc_o, operand1_o);
      else pass_cnt++;
   endtask

   task automatic test_flush_stall();
      clear_inputs();
      load_instr(32'h0000_0800, 5'd2, 32'h5, 5'd3, 32'h6, 32'h7, 4'd7, 1'b0, 1'b0, 5'd16, 1'b1);
      tick();
      stall_i = 1'b1; flush_i = 1'b1;
      tick();
      total_cnt++;
      if (ex_valid_o !== 1'b0 || ex_rd_wren_o !== 1'b0)
         $display("FAIL flush_stall: got %b/%b want 0/0", ex_valid_o, ex_rd_wren_o);
      else pass_cnt++;
      total_cnt++;
      if (alu_op_o !== 4'h0) $display("FAIL flush_aluop: got %h want 0", alu_op_o);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_stall();
      clear_inputs();
      load_instr(32'h0000_0900, 5'd2, 32'h5, 5'd3, 32'h6, 32'h7, 4'd8, 1'b1, 1'b0, 5'd17, 1'b1);
      tick();
      stall_i = 1'b1; rst_i = 1'b1;
      tick();
      total_cnt++;
      if (ex_valid_o !== 1'b0 || ex_pc_o !== 32'h0 || operand1_o !== 32'h0)
         $display("FAIL reset_mid_stall: got %b/%h/%h want 0/0/0", ex_valid_o, ex_pc_o,
                  operand1_o);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] pcs [3];
      logic [3:0]  ops [3];
      pcs[0] = 32'h0000_1000; pcs[1] = 32'h0000_1004; pcs[2] = 32'h0000_1008;
      ops[0] = 4'hA; ops[1] = 4'hB; ops[2] = 4'hC;
      clear_inputs();
      for (int i = 0; i < 3; i++) begin
         load_instr(pcs[i], 5'd1, 32'h100 + i, 5'd2, 32'h200 + i, 32'h0, ops[i],
                    1'b0, 1'b0, 5'd20 + 5'(i), 1'b1);
         tick();
         total_cnt++;
         if (ex_pc_o !== pcs[i] || alu_op_o !== ops[i] || operand2_o !== 32'h200 + i)
            $display("FAIL b2b_%0d: got %h/%h/%h want %h/%h/%h", i, ex_pc_o, alu_op_o,
                     operand2_o, pcs[i], ops[i], 32'h200 + i);
         else pass_cnt++;
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_operand_select();
      test_mem_forward();
      test_mem_over_wb();
      test_x0_guard();
      test_stall_refresh();
      test_flush_stall();
      test_reset_mid_stall();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
